// File: rtl/stack_queue_mem_ctrl_if.sv
// Bus between the operand store and its surroundings: button/switch inputs,
// the external ALU and the display/status outputs.
interface stack_queue_mem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int IN_W   = 16,
    parameter int DEPTH  = 16
);
    localparam int AW = $clog2(DEPTH);

    logic              stackQueue;
    logic [IN_W-1:0]   switches;
    logic [4:0]        btns;
    logic [DATA_W-1:0] aluY;
    logic [DATA_W-1:0] aluA;
    logic [DATA_W-1:0] aluB;
    logic [DATA_W-1:0] sseg;
    logic              empty;
    logic              full;
    logic [AW:0]       count;
    logic              busy;
    logic              err;

    // Environment side: drives commands and the ALU result
    modport master (
        output stackQueue, switches, btns, aluY,
        input  aluA, aluB, sseg, empty, full, count, busy, err
    );

    // Store side
    modport slave (
        input  stackQueue, switches, btns, aluY,
        output aluA, aluB, sseg, empty, full, count, busy, err
    );
endinterface

// File: rtl/stack_queue_mem_ctrl.sv
// Operand store for the stack/queue calculator. Holds DEPTH entries and works
// as a LIFO (stack) or FIFO (queue); an operate command feeds two entries to
// the external ALU and replaces them with its result.
module stack_queue_mem_ctrl #(
    parameter int DATA_W = 32,
    parameter int IN_W   = 16,
    parameter int DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    stack_queue_mem_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_TWO = (AW+1)'(2);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW-1:0] PTR_TWO = AW'(2);

    typedef enum logic [1:0] {IDLE, LOAD, EXEC} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [3:0]        btn_prev;
    logic [3:0]        btn_rise;
    logic              reserved_unused;
    logic              mode;       // 1 = stack, 0 = queue
    logic              mode_eff;
    logic [AW:0]       cnt;
    logic [AW:0]       cnt_m1, cnt_m2;
    logic [AW-1:0]     head, tail;
    logic [DATA_W-1:0] op_a, op_b;
    logic              err_q;
    logic              idle, is_empty, is_full;
    logic              do_clear, do_push, do_oper, do_pop;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DATA_W-1:0] wdata;

    assign reserved_unused = bus.btns[4];
    assign btn_rise = bus.btns[3:0] & ~btn_prev;
    assign idle     = (state == IDLE);
    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CNT_MAX);
    assign cnt_m1   = cnt - CNT_ONE;
    assign cnt_m2   = cnt - CNT_TWO;

    // Mode may only change while the store is idle and empty; using the live
    // switch value in that window keeps a push in the same cycle consistent.
    assign mode_eff = (idle && is_empty) ? bus.stackQueue : mode;

    // One command per cycle, clear > push > operate > pop; nothing while busy
    assign do_clear = idle & btn_rise[3];
    assign do_push  = idle & ~btn_rise[3] & btn_rise[0];
    assign do_oper  = idle & ~btn_rise[3] & ~btn_rise[0] & btn_rise[1];
    assign do_pop   = idle & ~btn_rise[3] & ~btn_rise[0] & ~btn_rise[1] & btn_rise[2];

    // Next state and the single memory write port (push or ALU write-back)
    always_comb begin
        state_nxt = state;
        we        = 1'b0;
        waddr     = '0;
        wdata     = '0;
        case (state)
            IDLE: begin
                if (do_oper && cnt >= CNT_TWO) state_nxt = LOAD;
                if (do_push && !is_full) begin
                    we    = 1'b1;
                    waddr = mode_eff ? cnt[AW-1:0] : tail;
                    wdata = DATA_W'(bus.switches);
                end
            end
            LOAD: state_nxt = EXEC;
            EXEC: begin
                state_nxt = IDLE;
                we        = 1'b1;
                waddr     = mode ? cnt_m2[AW-1:0] : tail;
                wdata     = bus.aluY;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Storage array; a reset edge suppresses any write-back in flight
    always_ff @(posedge clk) begin
        if (we && !rst) mem[waddr] <= wdata;
    end

    // Control state, pointers, operand registers and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            btn_prev <= '0;
            mode     <= bus.stackQueue;
            cnt      <= '0;
            head     <= '0;
            tail     <= '0;
            op_a     <= '0;
            op_b     <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            btn_prev <= bus.btns[3:0];
            mode     <= mode_eff;

            if (do_clear) begin
                cnt   <= '0;
                head  <= '0;
                tail  <= '0;
                err_q <= 1'b0;
            end else if (do_push) begin
                if (is_full) err_q <= 1'b1;
                else begin
                    cnt <= cnt + CNT_ONE;
                    if (!mode_eff) tail <= tail + PTR_ONE;
                end
            end else if (do_oper) begin
                if (cnt < CNT_TWO) err_q <= 1'b1;
            end else if (do_pop) begin
                if (is_empty) err_q <= 1'b1;
                else begin
                    cnt <= cnt_m1;
                    if (!mode) head <= head + PTR_ONE;
                end
            end

            if (state == LOAD) begin
                op_a <= mode ? mem[cnt_m2[AW-1:0]] : mem[head];
                op_b <= mode ? mem[cnt_m1[AW-1:0]] : mem[head + PTR_ONE];
            end

            // Two entries consumed, one result written: net count - 1
            if (state == EXEC) begin
                cnt <= cnt_m1;
                if (!mode) begin
                    head <= head + PTR_TWO;
                    tail <= tail + PTR_ONE;
                end
            end
        end
    end

    // Display shows the stack top or queue head, blank when empty
    always_comb begin
        bus.sseg = '0;
        if (!is_empty) bus.sseg = mode ? mem[cnt_m1[AW-1:0]] : mem[head];
    end

    assign bus.aluA  = op_a;
    assign bus.aluB  = op_b;
    assign bus.empty = is_empty;
    assign bus.full  = is_full;
    assign bus.count = cnt;
    assign bus.busy  = !idle;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_stack_queue_mem_ctrl.sv
// Directed bench: a DEPTH=16 and a DEPTH=4 store, each with an adder as ALU.
module tb_stack_queue_mem_ctrl;
    localparam int C_PUSH = 0, C_OPER = 1, C_POP = 2, C_CLR = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sq  = 1'b0;
    logic [15:0] sw  = '0;
    logic [4:0]  btns16 = '0, btns4 = '0;
    bit          sel = 1'b0;   // 0 = DEPTH16 unit, 1 = DEPTH4 unit
    bit          busy_seen;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    stack_queue_mem_ctrl_if #(.DATA_W(32), .IN_W(16), .DEPTH(16)) if16 ();
    stack_queue_mem_ctrl_if #(.DATA_W(32), .IN_W(16), .DEPTH(4))  if4 ();

    assign if16.stackQueue = sq;
    assign if16.switches   = sw;
    assign if16.btns       = btns16;
    assign if16.aluY       = if16.aluA + if16.aluB;
    assign if4.stackQueue  = sq;
    assign if4.switches    = sw;
    assign if4.btns        = btns4;
    assign if4.aluY        = if4.aluA + if4.aluB;

    stack_queue_mem_ctrl #(.DATA_W(32), .IN_W(16), .DEPTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
    stack_queue_mem_ctrl #(.DATA_W(32), .IN_W(16), .DEPTH(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));

    typedef struct {
        bit          dut;
        bit          mode;
        int          cmd;
        logic [15:0] data;
        int          hold;
        int          cnt;
        logic [31:0] sseg;
        bit          err;
        bit          chk_alu;
        logic [31:0] a;
        logic [31:0] b;
        bit          busy;
    } vec_t;

    vec_t vec[$];

    function automatic vec_t mk(bit d, bit m, int c, logic [15:0] x, int h, int n,
                                logic [31:0] s, bit e, bit ca, logic [31:0] a,
                                logic [31:0] b, bit bz);
        vec_t v;
        v.dut = d; v.mode = m; v.cmd = c; v.data = x; v.hold = h; v.cnt = n;
        v.sseg = s; v.err = e; v.chk_alu = ca; v.a = a; v.b = b; v.busy = bz;
        return v;
    endfunction

    function automatic int o_count();  return sel ? int'(if4.count) : int'(if16.count); endfunction
    function automatic logic [31:0] o_sseg(); return sel ? if4.sseg : if16.sseg; endfunction
    function automatic logic [31:0] o_a();    return sel ? if4.aluA : if16.aluA; endfunction
    function automatic logic [31:0] o_b();    return sel ? if4.aluB : if16.aluB; endfunction
    function automatic logic o_err();   return sel ? if4.err   : if16.err;   endfunction
    function automatic logic o_empty(); return sel ? if4.empty : if16.empty; endfunction
    function automatic logic o_full();  return sel ? if4.full  : if16.full;  endfunction
    function automatic logic o_busy();  return sel ? if4.busy  : if16.busy;  endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; sample 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (o_busy()) busy_seen = 1'b1;
    endtask

    task automatic set_btn(input int bit_idx, input logic v);
        if (sel) btns4[bit_idx] = v; else btns16[bit_idx] = v;
    endtask

    task automatic apply(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        sel = v.dut; sq = v.mode; sw = v.data;
        busy_seen = 1'b0;
        set_btn(v.cmd, 1'b1);
        repeat (v.hold) tick();
        set_btn(v.cmd, 1'b0);
        repeat (5) tick();
        chk({tag, ".count"}, 32'(o_count()), 32'(v.cnt));
        chk({tag, ".sseg"},  o_sseg(), v.sseg);
        chk({tag, ".err"},   32'(o_err()), 32'(v.err));
        chk({tag, ".empty"}, 32'(o_empty()), 32'(v.cnt == 0));
        chk({tag, ".full"},  32'(o_full()), 32'(v.cnt == (v.dut ? 4 : 16)));
        chk({tag, ".busy_seen"}, 32'(busy_seen), 32'(v.busy));
        if (v.chk_alu) begin
            chk({tag, ".aluA"}, o_a(), v.a);
            chk({tag, ".aluB"}, o_b(), v.b);
        end
    endtask

    initial begin
        // DEPTH16, queue: held pushes and one operate
        vec.push_back(mk(0,0,C_PUSH,16'hF0F0,100, 1,32'h0000F0F0,0, 0,0,0, 0));
        vec.push_back(mk(0,0,C_PUSH,16'hE3E3,100, 2,32'h0000F0F0,0, 0,0,0, 0));
        vec.push_back(mk(0,0,C_OPER,16'h0,    1,  1,32'h0001D4D3,0, 1,32'hF0F0,32'hE3E3, 1));
        vec.push_back(mk(0,0,C_POP, 16'h0,    1,  0,32'h0,0,       0,0,0, 0));
        vec.push_back(mk(0,0,C_POP, 16'h0,    1,  0,32'h0,1,       0,0,0, 0));
        vec.push_back(mk(0,0,C_CLR, 16'h0,    1,  0,32'h0,0,       0,0,0, 0));
        // DEPTH16, stack
        vec.push_back(mk(0,1,C_PUSH,16'd1,3, 1,32'd1,0, 0,0,0, 0));
        vec.push_back(mk(0,1,C_PUSH,16'd2,3, 2,32'd2,0, 0,0,0, 0));
        vec.push_back(mk(0,1,C_PUSH,16'd3,3, 3,32'd3,0, 0,0,0, 0));
        vec.push_back(mk(0,1,C_OPER,16'd0,1, 2,32'd5,0, 1,32'd2,32'd3, 1));
        vec.push_back(mk(0,1,C_OPER,16'd0,1, 1,32'd6,0, 1,32'd1,32'd5, 1));
        vec.push_back(mk(0,1,C_OPER,16'd0,1, 1,32'd6,1, 1,32'd1,32'd5, 0));
        // mode switch while non-empty is ignored: still a stack
        vec.push_back(mk(0,0,C_PUSH,16'd9,1, 2,32'd9,1, 0,0,0, 0));
        vec.push_back(mk(0,0,C_CLR, 16'd0,1, 0,32'd0,0, 0,0,0, 0));
        // DEPTH4, queue: fill, overflow, clear
        vec.push_back(mk(1,0,C_PUSH,16'hA,1, 1,32'hA,0, 0,0,0, 0));
        vec.push_back(mk(1,0,C_PUSH,16'hB,1, 2,32'hA,0, 0,0,0, 0));
        vec.push_back(mk(1,0,C_PUSH,16'hC,1, 3,32'hA,0, 0,0,0, 0));
        vec.push_back(mk(1,0,C_PUSH,16'hD,1, 4,32'hA,0, 0,0,0, 0));
        vec.push_back(mk(1,0,C_PUSH,16'hE,1, 4,32'hA,1, 0,0,0, 0));
        vec.push_back(mk(1,0,C_CLR, 16'h0,1, 0,32'h0,0, 0,0,0, 0));
        // DEPTH4, queue wrap
        vec.push_back(mk(1,0,C_PUSH,16'hA,1, 1,32'hA,0, 0,0,0, 0));
        vec.push_back(mk(1,0,C_PUSH,16'hB,1, 2,32'hA,0, 0,0,0, 0));
        vec.push_back(mk(1,0,C_PUSH,16'hC,1, 3,32'hA,0, 0,0,0, 0));
        vec.push_back(mk(1,0,C_PUSH,16'hD,1, 4,32'hA,0, 0,0,0, 0));
        vec.push_back(mk(1,0,C_POP, 16'h0,1, 3,32'hB,0, 0,0,0, 0));
        vec.push_back(mk(1,0,C_POP, 16'h0,1, 2,32'hC,0, 0,0,0, 0));
        vec.push_back(mk(1,0,C_PUSH,16'hE,1, 3,32'hC,0, 0,0,0, 0));
        vec.push_back(mk(1,0,C_PUSH,16'hF,1, 4,32'hC,0, 0,0,0, 0));
        vec.push_back(mk(1,0,C_POP, 16'h0,1, 3,32'hD,0, 0,0,0, 0));
        vec.push_back(mk(1,0,C_POP, 16'h0,1, 2,32'hE,0, 0,0,0, 0));
        vec.push_back(mk(1,0,C_POP, 16'h0,1, 1,32'hF,0, 0,0,0, 0));
        vec.push_back(mk(1,0,C_POP, 16'h0,1, 0,32'h0,0, 0,0,0, 0));
        // DEPTH4, queue operate with head/tail wrapping (head=tail=2 here)
        vec.push_back(mk(1,0,C_PUSH,16'd1,1, 1,32'd1,0, 0,0,0, 0));
        vec.push_back(mk(1,0,C_PUSH,16'd2,1, 2,32'd1,0, 0,0,0, 0));
        vec.push_back(mk(1,0,C_PUSH,16'd7,1, 3,32'd1,0, 0,0,0, 0));
        vec.push_back(mk(1,0,C_OPER,16'd0,1, 2,32'd7,0, 1,32'd1,32'd2, 1));
        vec.push_back(mk(1,0,C_POP, 16'd0,1, 1,32'd3,0, 0,0,0, 0));

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        sel = 1'b0;
        chk("rst.count", 32'(o_count()), 32'd0);
        chk("rst.empty", 32'(o_empty()), 32'd1);
        chk("rst.full",  32'(o_full()),  32'd0);
        chk("rst.busy",  32'(o_busy()),  32'd0);
        chk("rst.err",   32'(o_err()),   32'd0);
        chk("rst.aluA",  o_a(), 32'd0);
        chk("rst.aluB",  o_b(), 32'd0);
        chk("rst.sseg",  o_sseg(), 32'd0);

        for (int i = 0; i < vec.size(); i++) begin
            if (i == 13) begin
                // Push arriving while an operate is in progress is dropped
                sel = 1'b0; sq = 1'b0; sw = 16'h55;
                btns16 = 5'b00010;
                tick();
                btns16 = 5'b00001;
                tick();
                btns16 = 5'b00000;
                repeat (5) tick();
                chk("drop.count", 32'(o_count()), 32'd1);
                chk("drop.sseg",  o_sseg(), 32'hF);
                chk("drop.aluA",  o_a(), 32'd6);
                chk("drop.aluB",  o_b(), 32'd9);
            end
            apply(vec[i], i);
        end

        // Reset while EXEC is in flight aborts with no write-back
        apply(mk(0,0,C_PUSH,16'd3,1, 1,32'd3,0, 0,0,0, 0), 100);
        apply(mk(0,0,C_PUSH,16'd4,1, 2,32'd3,0, 0,0,0, 0), 101);
        sel = 1'b0;
        btns16 = 5'b00010;
        tick();
        chk("exec.busy_rise", 32'(o_busy()), 32'd1);
        btns16 = 5'b00000;
        tick();
        rst = 1'b1;
        #1;
        chk("exec.rst_count", 32'(o_count()), 32'd0);
        chk("exec.rst_aluA",  o_a(), 32'd0);
        chk("exec.rst_aluB",  o_b(), 32'd0);
        chk("exec.rst_busy",  32'(o_busy()), 32'd0);
        chk("exec.rst_empty", 32'(o_empty()), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        apply(mk(0,0,C_PUSH,16'h0007,1, 1,32'd7,0, 0,0,0, 0), 102);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stack_queue_mem_ctrl.md
Name: stack_queue_mem_ctrl

Overview:
Parametrised operand store for the stack/queue calculator. It holds DEPTH entries of DATA_W bits and operates as a LIFO or a FIFO. It accepts push, operate, pop and clear commands from the button bank. An operate command presents the two oldest (queue) or two newest (stack) entries to the external ALU, then replaces both with the ALU result. The block sits between the switch/button inputs, the ALU and the seven-segment display driver.

Parameters:
DATA_W, 32, width of stored entries and of the ALU interface.
IN_W, 16, width of the switch input; zero-extended to DATA_W on push.
DEPTH, 16, number of entries; must be a power of two and at least 4.
AW (localparam), $clog2(DEPTH), pointer width.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
stackQueue  in  1  mode: 0 = queue (FIFO), 1 = stack (LIFO)
switches  in  IN_W  push data
btns  in  5  commands; [0] push, [1] operate, [2] pop/discard, [3] clear, [4] reserved (ignored); already debounced and synchronous to clk
aluY  in  DATA_W  ALU result, combinational from aluA/aluB
aluA  out  DATA_W  registered first operand
aluB  out  DATA_W  registered second operand
sseg  out  DATA_W  display value: stack top or queue head; 0 when empty
empty  out  1  count == 0
full  out  1  count == DEPTH
count  out  AW+1  number of valid entries
busy  out  1  high while the operate sequence is in progress
err  out  1  sticky error flag

Behaviour:
- Reset: count=0, head=tail=0, aluA=aluB=0, err=0, busy=0, state=IDLE, previous-button register=0, latched mode=stackQueue. Memory contents are don't-care.
- Button handling: each bit is rising-edge detected against a registered copy. A held button produces exactly one action.
- Command priority within one cycle: clear > push > operate > pop. One command per cycle.
- Commands detected while busy are dropped and do not set err.
- Mode latch: stackQueue is latched only in IDLE when count==0. Changes while non-empty are ignored.
- Push: if not full, writes {zero-extended switches} and increments count. If full, no change and err<=1.
  - Stack: write at index count.
  - Queue: write at tail; tail wraps mod DEPTH.
- Pop: if count>=1, discards the top (stack) or head (queue) and decrements count. Otherwise no change and err<=1.
- Clear: count=0, head=tail=0, err=0. Does not reset aluA/aluB.
- Operate FSM, IDLE -> LOAD -> EXEC -> IDLE:
  - IDLE: on an operate edge with count>=2, go to LOAD and set busy=1. With count<2, stay in IDLE and set err<=1.
  - LOAD: register the operands.
    - Stack: aluA<=mem[count-2], aluB<=mem[count-1].
    - Queue: aluA<=mem[head], aluB<=mem[head+1 mod DEPTH].
  - EXEC: sample aluY at the end of the cycle.
    - Stack: mem[count-2]<=aluY.
    - Queue: head<=head+2 (wrapping) and mem[tail]<=aluY, tail<=tail+1. The net effect is count-1, so a queue can never overflow here.
    - count<=count-1, busy<=0, return to IDLE.
  - Timing: with the edge detected in cycle N, aluA/aluB are valid from cycle N+2 and the result is visible on sseg/count from cycle N+3.
- sseg is combinational from the array: mem[count-1] in stack mode, mem[head] in queue mode, 0 when empty.
- aluA/aluB hold their last operands outside LOAD.
- Arithmetic: the aluY overflow is not checked; the result is stored truncated to DATA_W.
- Reset asserted mid-sequence, including during EXEC, aborts immediately to the reset state. No partial write back.

Test Plan:
- Queue mode, DEPTH=16: push 0xF0F0, push 0xE3E3 (each button held 100 clocks), operate -> aluA=0x0000F0F0, aluB=0x0000E3E3, sseg=0x0001D4D3, count=1, err=0. Exactly one push per held press.
- Stack mode: push 1, 2, 3; operate -> aluA=2, aluB=3, sseg=5, count=2. Operate again -> aluA=1, aluB=5, sseg=6, count=1.
- DEPTH=4: push 4 values -> full=1. 5th push -> count stays 4, err=1. Clear -> count=0, empty=1, err=0.
- Underflow: count=1, press operate -> no state change, busy never asserts, err=1. Pop from empty -> err=1.
- Queue wrap, DEPTH=4: push A,B,C,D; pop, pop; push E,F; successive pops show sseg = C, D, E, F in that order, then empty=1.
- Reset in EXEC: assert rst one cycle after busy rises -> count=0, aluA=aluB=0, busy=0 immediately. A subsequent push of 0x0007 gives sseg=7.
